// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding and length-field width used by imem_loader and its bench.
// No logic lives here.
package imem_loader_pkg;

  // Width of the big-endian word-count header at the start of the image
  localparam int LEN_W = 16;

  // 3-bit state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LEN_HI = ST_LEN_HI,
    S_LEN_LO = ST_LEN_LO,
    S_DATA   = ST_DATA,
    S_CHECK  = ST_CHECK,
    S_DONE   = ST_DONE,
    S_ERROR  = ST_ERROR
  } state_e;

  // States in which a stream byte can be consumed
  function automatic logic is_rx_state(state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_xor_accum.sv
// Running XOR of the accepted image bytes, used as the load checksum.
// Latency: result reflects an enabled byte one cycle after it is presented.
// Backpressure: none; the caller gates i_en with its own handshake.
module xor_accum (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_dat,
  output logic [7:0] o_acc
);

  logic [7:0] acc_q, acc_d;

  // Clear has priority so a restart never mixes in a stale byte
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = 8'h00;
    end else if (i_en) begin
      acc_d = acc_q ^ i_dat;
    end
  end

  // Accumulator register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> instruction RAM, core held in reset until checksum OK.
// Latency: write strobe one cycle after the 4th byte of a word; status one cycle after the checksum byte.
// Backpressure: o_ready is high only while a stream byte can be consumed; one byte per cycle otherwise.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_core_rst_n,
  output logic        o_done,
  output logic        o_error
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              start_ok;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   idx_inc;
  logic [7:0]        csum;

  assign o_ready  = is_rx_state(state_q);
  assign accept   = i_valid && o_ready;
  assign start_ok = i_start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign len_full = {len_q[LEN_W-1:8], i_byte};
  assign idx_inc  = idx_q + (ADDR_W+1)'(1);

  // Checksum covers every byte except the checksum byte itself
  xor_accum u_xor_accum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (start_ok),
    .i_en    (accept && (state_q != S_CHECK)),
    .i_dat   (i_byte),
    .o_acc   (csum)
  );

  // Next-state, word assembly and registered-output decode
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bcnt_d       = bcnt_q;
    word_d       = word_q;
    idx_d        = idx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok) begin
          state_d      = S_LEN_HI;
          bcnt_d       = 2'd0;
          idx_d        = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          core_rst_n_d = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {i_byte, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          // A count of exactly 2^ADDR_W fills the RAM and is legal
          if (32'(len_full) > (32'd1 << ADDR_W)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (len_full == '0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          word_d = {word_q[15:0], i_byte};
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {word_q, i_byte};
            wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
            idx_d     = idx_inc;
            if (32'(idx_inc) == 32'(len_q)) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (i_byte == csum) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state and outputs register here; reset abandons any partial image
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      bcnt_q       <= 2'd0;
      word_q       <= '0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= 32'h0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W = 8, BASE_ADDR = 0).
// Table of whole-image vectors plus hand sequences for reset, ignored start and full-capacity load.
// Expected RAM writes go into a queue when an image is driven and are popped by a write monitor.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_valid;
  logic [7:0]  i_byte;
  logic        o_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_core_rst_n;
  logic        o_done;
  logic        o_error;

  int n_chk  = 0;
  int n_fail = 0;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_byte       (i_byte),
    .o_ready      (o_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_core_rst_n (o_core_rst_n),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];

  typedef struct packed {
    logic [0:11][7:0] bytes;
    logic [3:0]       nbytes;
    logic             gaps;
    logic             exp_done;
    logic             exp_err;
    logic [1:0]       nw;
    logic [0:1][31:0] wa;
    logic [0:1][31:0] wd;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  // Every write strobe must match the next expected write, in order, once
  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      wr_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", o_wr_addr, o_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", o_wr_addr, e.a);
        chk("wr_data", o_wr_data, e.d);
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic do_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_ready", 32'(o_ready), 32'd1);
    chk("start_done_clr", 32'(o_done), 32'd0);
    chk("start_err_clr", 32'(o_error), 32'd0);
    chk("start_core_rst", 32'(o_core_rst_n), 32'd0);
  endtask

  // Present one byte until it is accepted; optional random idle cycles first
  task automatic send_byte(input logic [7:0] b, input logic gaps, input logic st);
    int t;
    if (gaps) begin
      int k;
      k = int'($urandom_range(0, 3));
      for (int g = 0; g < k; g++) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
    end
    @(negedge clk);
    i_valid = 1'b1;
    i_byte  = b;
    i_start = st;
    t = 0;
    while (!o_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got ready 0 for 20 cycles, required ready 1");
      i_valid = 1'b0;
      i_start = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_start = 1'b0;
    end
  endtask

  task automatic check_status(input logic d, input logic e);
    chk("done", 32'(o_done), 32'(d));
    chk("error", 32'(o_error), 32'(e));
    chk("core_rst_n", 32'(o_core_rst_n), 32'(d));
    chk("ready_after_end", 32'(o_ready), 32'd0);
    chk("writes_outstanding", 32'(sb.size()), 32'd0);
  endtask

  vec_t vt[5];
  logic [0:9][7:0] good;
  logic [7:0] cs;

  initial begin
    // Payload 24080005, 0000000C; 0x27 is the XOR of the ten bytes before it
    good = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

    vt[0] = '{bytes: {good, 8'h27, 8'h00}, nbytes: 4'd11, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0,
              nw: 2'd2, wa: {32'h0, 32'h4}, wd: {32'h24080005, 32'h0000000C}};
    vt[1] = '{bytes: {good, 8'h0E, 8'h00}, nbytes: 4'd11, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1,
              nw: 2'd2, wa: {32'h0, 32'h4}, wd: {32'h24080005, 32'h0000000C}};
    vt[2] = '{bytes: {8'h00, 8'h00, 8'h00, 72'h0}, nbytes: 4'd3, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0,
              nw: 2'd0, wa: '0, wd: '0};
    vt[3] = '{bytes: {8'h01, 8'h01, 80'h0}, nbytes: 4'd2, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1,
              nw: 2'd0, wa: '0, wd: '0};
    vt[4] = '{bytes: {good, 8'h27, 8'h00}, nbytes: 4'd11, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0,
              nw: 2'd2, wa: {32'h0, 32'h4}, wd: {32'h24080005, 32'h0000000C}};

    i_start = 1'b0;
    i_valid = 1'b0;
    i_byte  = 8'h00;
    rst_n   = 1'b0;
    #23;
    rst_n = 1'b1;

    // Idle after reset: core held, nothing consumed, no writes
    repeat (10) @(negedge clk);
    chk("rst_core_rst_n", 32'(o_core_rst_n), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_wr_addr", o_wr_addr, 32'h0);
    chk("rst_wr_data", o_wr_data, 32'h0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < int'(vt[v].nw); j++) push_wr(vt[v].wa[j], vt[v].wd[j]);
      do_start();
      for (int j = 0; j < int'(vt[v].nbytes); j++) send_byte(vt[v].bytes[j], vt[v].gaps, 1'b0);
      check_status(vt[v].exp_done, vt[v].exp_err);
      // Valid bytes offered while not ready must be ignored
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = 8'hAA;
      repeat (3) @(negedge clk);
      i_valid = 1'b0;
      check_status(vt[v].exp_done, vt[v].exp_err);
    end

    // i_start during a load is ignored
    push_wr(32'h0, 32'h24080005);
    push_wr(32'h4, 32'h0000000C);
    do_start();
    for (int j = 0; j < 10; j++) send_byte(good[j], 1'b0, (j >= 3 && j <= 6));
    send_byte(8'h27, 1'b0, 1'b0);
    check_status(1'b1, 1'b0);

    // Reset after six bytes: the pending write is wiped, then a clean rerun
    do_start();
    for (int j = 0; j < 6; j++) send_byte(good[j], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(o_wr_en), 32'd0);
    chk("midrst_wr_data", o_wr_data, 32'h0);
    chk("midrst_wr_addr", o_wr_addr, 32'h0);
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_core_rst", 32'(o_core_rst_n), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_wr(32'h0, 32'h24080005);
    push_wr(32'h4, 32'h0000000C);
    do_start();
    for (int j = 0; j < 10; j++) send_byte(good[j], 1'b0, 1'b0);
    send_byte(8'h27, 1'b0, 1'b0);
    check_status(1'b1, 1'b0);

    // Full capacity: N = 256 words is legal and fills addresses 0..0x3FC
    do_start();
    cs = 8'h01;
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    chk("cap_no_error", 32'(o_error), 32'd0);
    chk("cap_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0]  ib;
      logic [31:0] w;
      ib = 8'(i);
      w  = {ib, ~ib, 8'h5A, 8'hC3};
      push_wr(32'(i) << 2, w);
      for (int k = 3; k >= 0; k--) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], 1'b0, 1'b0);
      end
    end
    send_byte(cs, 1'b0, 1'b0);
    check_status(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test by 400000, required finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
